vid_to_axis: RTL and testbench

VID_TO_AXIS -- requirements
Module: vid_to_axis

---
 rtl/vid_to_axis.sv | 179 +++++++++++++++++
 tb/tb_vid_to_axis.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vid_to_axis.sv
// Converts fval/lval/dval video into an AXI4-Stream pixel stream through a first-word-fall-through FIFO.
// Latency: a pixel accepted at edge N shows m_tvalid=1 after edge N+1.
// Backpressure: while m_tready=0 the FIFO head is held; pixels reaching a full FIFO are dropped and overflow is set.

module vid_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign pop_vld  = (count != '0);
  assign do_pop   = pop_vld && pop_rdy;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push_rdy = (count != FULL_CNT) || do_pop;
  assign do_push  = push_vld && push_rdy;
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module vid_to_axis #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int BPP        = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fval,
  input  logic           lval,
  input  logic           dval,
  input  logic [BPP-1:0] pix_data,
  output logic [BPP-1:0] m_tdata,
  output logic           m_tvalid,
  input  logic           m_tready,
  output logic           m_tuser,
  output logic           m_tlast,
  output logic           overflow,
  output logic           size_err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam logic [CW-1:0] W_CNT  = WIDTH[CW-1:0];
  localparam logic [CW-1:0] W_LAST = W_CNT - 1'b1;
  localparam logic [RW-1:0] H_CNT  = HEIGHT[RW-1:0];

  typedef struct packed {
    logic           tuser;
    logic           tlast;
    logic [BPP-1:0] data;
  } pix_ent_t;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state, state_nxt;
  logic          fval_d, lval_d;
  logic          fval_rise, fval_fall, lval_rise, lval_fall;
  logic          active, accept, in_range, lval_end;
  logic [CW-1:0] col, col_eff;
  logic [RW-1:0] row, row_nxt;
  pix_ent_t      pix_ent, wr_ent, head_ent;
  logic          wr_vld, wr_rdy;

  assign fval_rise = fval && !fval_d;
  assign fval_fall = !fval && fval_d;
  assign lval_rise = lval && !lval_d;
  assign lval_fall = !lval && lval_d;
  assign active    = (state == ACTIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fval_rise) state_nxt = ACTIVE;
      ACTIVE:  if (fval_fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    // A pixel arriving with the lval rising edge belongs to column 0.
    col_eff       = (fval_rise || lval_rise) ? '0 : col;
    accept        = active && fval && lval && dval;
    in_range      = (col_eff < W_CNT) && (row < H_CNT);
    lval_end      = active && lval_fall;
    pix_ent.tuser = (row == '0) && (col_eff == '0);
    pix_ent.tlast = (col_eff == W_LAST);
    pix_ent.data  = pix_data;
    row_nxt       = row;
    if (lval_end && (row != H_CNT)) row_nxt = row + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Start high so a frame already running at reset release is skipped.
      fval_d   <= 1'b1;
      lval_d   <= 1'b0;
      col      <= '0;
      row      <= '0;
      wr_vld   <= 1'b0;
      wr_ent   <= '0;
      overflow <= 1'b0;
      size_err <= 1'b0;
    end else begin
      fval_d <= fval;
      lval_d <= lval;
      if (fval_rise) begin
        col <= '0;
        row <= '0;
      end else begin
        row <= row_nxt;
        if (accept && (col_eff != W_CNT)) col <= col_eff + 1'b1;
        else                              col <= col_eff;
      end
      wr_vld <= accept && in_range;
      if (accept && in_range) wr_ent <= pix_ent;
      if (wr_vld && !wr_rdy) overflow <= 1'b1;
      if ((accept && !in_range) ||
          (lval_end && (col != W_CNT)) ||
          (active && fval_fall && (row_nxt != H_CNT)))
        size_err <= 1'b1;
    end
  end

  vid_fifo #(
    .W     ($bits(pix_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (wr_vld),
    .push_dat (wr_ent),
    .push_rdy (wr_rdy),
    .pop_vld  (m_tvalid),
    .pop_rdy  (m_tready),
    .pop_dat  (head_ent)
  );

  assign m_tdata = head_ent.data;
  assign m_tuser = head_ent.tuser;
  assign m_tlast = head_ent.tlast;
endmodule

// File: tb/tb_vid_to_axis.sv
// Directed bench for vid_to_axis at WIDTH=4, HEIGHT=2, FIFO_DEPTH=4, BPP=8.
module tb_vid_to_axis;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fval = 1'b0, lval = 1'b0, dval = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       m_tready = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tuser, m_tlast, overflow, size_err;

  int checks = 0;
  int failures = 0;
  logic [9:0] beats[$];

  vid_to_axis #(.WIDTH(4), .HEIGHT(2), .BPP(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .fval(fval), .lval(lval), .dval(dval), .pix_data(pix_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .overflow(overflow), .size_err(size_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && m_tvalid && m_tready) beats.push_back({m_tuser, m_tlast, m_tdata});

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    rst = 1'b1; fval = 1'b0; lval = 1'b0; dval = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    beats.delete();
  endtask

  task automatic send_line(input int n, input int base, input int gap);
    lval = 1'b1; dval = 1'b1;
    for (int i = 0; i < n; i++) begin pix_data = 8'(base + i); tick(); end
    lval = 1'b0; dval = 1'b0;
    tick(gap);
  endtask

  task automatic send_frame(input int n0, input int b0, input int n1, input int b1, input int gap);
    fval = 1'b1; tick();
    send_line(n0, b0, gap);
    send_line(n1, b1, gap);
    fval = 1'b0; tick(2);
  endtask

  task automatic test_reset;
    tick(2);
    checks++; if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== 11'd0) begin failures++;
      $display("FAIL reset_outputs got=%h exp=0", {m_tvalid, m_tdata, m_tuser, m_tlast}); end
    checks++; if ({overflow, size_err} !== 2'b00) begin failures++;
      $display("FAIL reset_flags got=%b exp=00", {overflow, size_err}); end
    rst = 1'b0; tick(1);
  endtask

  task automatic test_nominal;
    logic [9:0] exp, got;
    do_reset(); m_tready = 1'b1;
    send_frame(4, 1, 4, 5, 1);
    tick(4);
    checks++; if (beats.size() != 8) begin failures++;
      $display("FAIL nominal_count got=%0d exp=8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      exp = {(i == 0), (i == 3 || i == 7), 8'(i + 1)};
      got = (i < beats.size()) ? beats[i] : 10'hx;
      checks++; if (got !== exp) begin failures++;
        $display("FAIL nominal_beat%0d got=%h exp=%h", i, got, exp); end
    end
    checks++; if ({overflow, size_err} !== 2'b00) begin failures++;
      $display("FAIL nominal_flags got=%b exp=00", {overflow, size_err}); end
  endtask

  task automatic test_latency;
    do_reset(); m_tready = 1'b0;
    fval = 1'b1; tick();
    lval = 1'b1; dval = 1'b1; pix_data = 8'h5A; tick();
    lval = 1'b0; dval = 1'b0;
    checks++; if (m_tvalid !== 1'b0) begin failures++;
      $display("FAIL latency_edgeN got=%b exp=0", m_tvalid); end
    tick();
    checks++; if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== {3'b110, 8'h5A}) begin failures++;
      $display("FAIL latency_edgeN1 got=%h exp=%h", {m_tvalid, m_tuser, m_tlast, m_tdata}, {3'b110, 8'h5A}); end
    fval = 1'b0; tick(2);
  endtask

  task automatic test_backpressure;
    logic [9:0] exp, got;
    do_reset(); m_tready = 1'b0;
    send_frame(4, 1, 4, 5, 1);
    checks++; if ({overflow, size_err} !== 2'b10) begin failures++;
      $display("FAIL bp_flags got=%b exp=10", {overflow, size_err}); end
    checks++; if ({m_tvalid, m_tuser, m_tdata} !== {2'b11, 8'd1}) begin failures++;
      $display("FAIL bp_head got=%h exp=%h", {m_tvalid, m_tuser, m_tdata}, {2'b11, 8'd1}); end
    m_tready = 1'b1; tick(8);
    checks++; if (beats.size() != 4) begin failures++;
      $display("FAIL bp_count got=%0d exp=4", beats.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = {(i == 0), (i == 3), 8'(i + 1)};
      got = (i < beats.size()) ? beats[i] : 10'hx;
      checks++; if (got !== exp) begin failures++;
        $display("FAIL bp_beat%0d got=%h exp=%h", i, got, exp); end
    end
    checks++; if (m_tvalid !== 1'b0) begin failures++;
      $display("FAIL bp_drained got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_short_line;
    logic [7:0] exp_d [7] = '{1, 2, 3, 5, 6, 7, 8};
    logic [9:0] exp, got;
    do_reset(); m_tready = 1'b1;
    fval = 1'b1; tick();
    send_line(3, 1, 0);
    checks++; if (size_err !== 1'b0) begin failures++;
      $display("FAIL short_before got=%b exp=0", size_err); end
    tick();
    checks++; if (size_err !== 1'b1) begin failures++;
      $display("FAIL short_after got=%b exp=1", size_err); end
    send_line(4, 5, 1);
    fval = 1'b0; tick(4);
    checks++; if (beats.size() != 7) begin failures++;
      $display("FAIL short_count got=%0d exp=7", beats.size()); end
    for (int i = 0; i < 7; i++) begin
      exp = {(i == 0), (i == 6), exp_d[i]};
      got = (i < beats.size()) ? beats[i] : 10'hx;
      checks++; if (got !== exp) begin failures++;
        $display("FAIL short_beat%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_long_line;
    logic [7:0] exp_d [8] = '{1, 2, 3, 4, 11, 12, 13, 14};
    logic [9:0] exp, got;
    do_reset(); m_tready = 1'b1;
    send_frame(5, 1, 4, 11, 1);
    tick(4);
    checks++; if (beats.size() != 8) begin failures++;
      $display("FAIL long_count got=%0d exp=8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      exp = {(i == 0), (i == 3 || i == 7), exp_d[i]};
      got = (i < beats.size()) ? beats[i] : 10'hx;
      checks++; if (got !== exp) begin failures++;
        $display("FAIL long_beat%0d got=%h exp=%h", i, got, exp); end
    end
    checks++; if ({overflow, size_err} !== 2'b01) begin failures++;
      $display("FAIL long_flags got=%b exp=01", {overflow, size_err}); end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] exp, got;
    do_reset(); m_tready = 1'b0;
    fval = 1'b1; tick();
    lval = 1'b1; dval = 1'b1;
    pix_data = 8'd1; tick();
    pix_data = 8'd2; tick();
    rst = 1'b1; tick();
    checks++; if (m_tvalid !== 1'b0) begin failures++;
      $display("FAIL midrst_flush got=%b exp=0", m_tvalid); end
    rst = 1'b0; m_tready = 1'b1; beats.delete();
    pix_data = 8'd3; tick();
    pix_data = 8'd4; tick();
    lval = 1'b0; dval = 1'b0; tick();
    send_line(4, 5, 1);
    fval = 1'b0; tick(3);
    checks++; if (beats.size() != 0) begin failures++;
      $display("FAIL midrst_quiet got=%0d exp=0", beats.size()); end
    checks++; if ({overflow, size_err} !== 2'b00) begin failures++;
      $display("FAIL midrst_flags got=%b exp=00", {overflow, size_err}); end
    send_frame(4, 21, 4, 25, 1);
    tick(4);
    checks++; if (beats.size() != 8) begin failures++;
      $display("FAIL midrst_count got=%0d exp=8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      exp = {(i == 0), (i == 3 || i == 7), 8'(21 + i)};
      got = (i < beats.size()) ? beats[i] : 10'hx;
      checks++; if (got !== exp) begin failures++;
        $display("FAIL midrst_beat%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_stall;
    logic [9:0] prev, exp, got;
    logic prev_hold;
    prev = '0; prev_hold = 1'b0;
    do_reset(); m_tready = 1'b0;
    fork
      send_frame(4, 1, 4, 5, 4);
      begin
        for (int c = 0; c < 60; c++) begin m_tready = ~m_tready; tick(); end
        m_tready = 1'b1;
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (prev_hold) begin
            checks++; if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== {1'b1, prev}) begin failures++;
              $display("FAIL stall_hold got=%h exp=%h", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, prev}); end
          end
          prev_hold = m_tvalid && !m_tready;
          prev = {m_tuser, m_tlast, m_tdata};
        end
      end
    join
    tick(2);
    checks++; if (beats.size() != 8) begin failures++;
      $display("FAIL stall_count got=%0d exp=8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      exp = {(i == 0), (i == 3 || i == 7), 8'(i + 1)};
      got = (i < beats.size()) ? beats[i] : 10'hx;
      checks++; if (got !== exp) begin failures++;
        $display("FAIL stall_beat%0d got=%h exp=%h", i, got, exp); end
    end
    checks++; if ({overflow, size_err} !== 2'b00) begin failures++;
      $display("FAIL stall_flags got=%b exp=00", {overflow, size_err}); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_latency();
    test_backpressure();
    test_short_line();
    test_long_line();
    test_reset_mid_frame();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
